cal_unit: RTL and testbench
===========================

CAL_UNIT -- requirements
Module: cal_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 2*WIDTH+4: accumulator and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active for all state.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cal_start, input, 1 bit: request from controller to start one multiply-accumulate.
REQ-006 SHALL have port acc_clr, input, 1 bit: clear the accumulator (see Function).
REQ-007 SHALL have port op_a, input, WIDTH bits: multiplicand, unsigned.
REQ-008 SHALL have port op_b, input, WIDTH bits: multiplier, unsigned.
REQ-009 SHALL have port cal_finish, output, 1 bit: one-cycle completion pulse to controller.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port result, output, ACC_W bits: accumulated value.
REQ-012 SHALL have port overflow, output, 1 bit: sticky accumulator carry-out flag.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with cal_start=1, latch op_a and op_b on that edge, clear the partial product and bit counter, and move to CALC.
REQ-015 SHALL, in CALC, process one multiplier bit per edge (LSB first, shift-add into a 2*WIDTH partial-product register), for exactly WIDTH edges, then move to DONE; latency is fixed with no early exit on zero operands.
REQ-016 SHALL, on the CALC->DONE edge, update result to acc_base + product mod 2^ACC_W:
  - acc_base = 0 if acc_clr was 1 when cal_start was accepted;
  - otherwise acc_base = the previous result.
REQ-017 SHALL set overflow on the CALC->DONE edge if that addition carries out of ACC_W bits; overflow stays set until cleared.
REQ-018 SHALL assert cal_finish=1 only in DONE, for exactly one cycle, then return to IDLE on the next edge.
REQ-019 SHALL hold result stable and valid from DONE entry until the next DONE entry or clear; result SHALL NOT change during CALC.
REQ-020 SHALL drive busy=1 in CALC and DONE, and busy=0 in IDLE.
REQ-021 SHALL ignore cal_start in CALC and DONE (no queuing); cal_start held high SHALL yield back-to-back operations with cal_finish period WIDTH+2 cycles.
REQ-022 SHALL, in IDLE with acc_clr=1 and cal_start=0, clear result and overflow to 0 on the next edge, with no cal_finish.
REQ-023 SHALL ignore acc_clr in CALC and DONE.
REQ-024 SHALL, when acc_clr=1 accompanies cal_start, clear overflow on the accept edge.
REQ-025 SHALL ignore op_a and op_b changes after the accept edge.

Reset
REQ-026 SHALL, while rst=0 and asynchronously, force state IDLE with counter, partial product, latched operands, result and overflow all 0, and cal_finish=0, busy=0.
REQ-027 SHALL abort any in-flight operation on reset without updating result, and SHALL accept no cal_start until the first rising edge after rst returns to 1.

Verification
REQ-028 SHALL cover: op_a=3, op_b=5, acc_clr=1, cal_start pulsed 1 cycle -> cal_finish high for exactly the cycle after the 16th edge following acceptance, result=15, overflow=0, busy low after.
REQ-029 SHALL cover: then op_a=0xFFFF, op_b=0xFFFF, acc_clr=0 -> result=0x0FFFE0010, overflow=0.
REQ-030 SHALL cover: acc_clr=1 then 17 ops of 0xFFFF*0xFFFF -> after op 16 overflow=0; after op 17 overflow=1, result=0x0FFDE0011.
REQ-031 SHALL cover: cal_start held high for 40 cycles with op_a=1, op_b=1, acc_clr=0 from result=0 -> cal_finish pulses exactly 18 cycles apart, result increments by 1 each pulse.
REQ-032 SHALL cover: rst driven low 5 cycles into CALC -> immediately busy=0, result=0, overflow=0; no cal_finish afterwards until a new cal_start.
REQ-033 SHALL cover: IDLE, result=15, acc_clr=1, cal_start=0 for one cycle -> result=0, overflow=0 next edge, cal_finish stays 0.

Source files
------------

// File: rtl/cal_unit.sv
// cal_unit: sequential shift-add multiplier feeding a wide accumulator.
// One multiplier bit is consumed per clock (LSB first). The product is added
// to the running result on the CALC->DONE edge. cal_finish pulses for the
// single DONE cycle.
module cal_unit #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             cal_finish,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pp;       // partial product
  logic [PW-1:0]    a_sh;     // multiplicand, shifted left each step
  logic [WIDTH-1:0] b_sh;     // multiplier, shifted right each step
  logic             clr_q;    // acc_clr captured at accept: start from zero
  logic [PW-1:0]    pp_next;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;

  // Next partial product and the final accumulate, with carry-out kept.
  always_comb begin
    pp_next  = pp + (b_sh[0] ? a_sh : '0);
    acc_base = clr_q ? '0 : result;
    sum      = {1'b0, acc_base} + (ACC_W+1)'(pp_next);
  end

  // FSM, datapath and accumulator state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pp       <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      clr_q    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cal_start) begin
            a_sh  <= {{WIDTH{1'b0}}, op_a};
            b_sh  <= op_b;
            pp    <= '0;
            cnt   <= '0;
            clr_q <= acc_clr;
            if (acc_clr) overflow <= 1'b0;
            state <= CALC;
          end else if (acc_clr) begin
            result   <= '0;
            overflow <= 1'b0;
          end
        end
        CALC: begin
          pp   <= pp_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          // Fixed WIDTH steps regardless of operand values.
          if (cnt == CW'(WIDTH-1)) begin
            result <= sum[ACC_W-1:0];
            if (sum[ACC_W]) overflow <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cal_finish = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cal_unit.sv
// Bench for cal_unit: vector table plus hand sequences. Expected results are
// queued when an operation is issued and popped when cal_finish is seen.
module tb_cal_unit;
  localparam int WIDTH = 16;
  localparam int ACC_W = 2*WIDTH+4;

  logic             clk, rst, cal_start, acc_clr;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cal_finish, busy, overflow;
  logic [ACC_W-1:0] result;

  cal_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start), .acc_clr(acc_clr),
    .op_a(op_a), .op_b(op_b), .cal_finish(cal_finish), .busy(busy),
    .result(result), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic [ACC_W-1:0] r;
    logic             ov;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] r;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for cal_finish (bounded), then compare against the scoreboard head.
  task automatic wait_finish(input logic [ACC_W-1:0] prev);
    int   n;
    logic moved;
    exp_t e;
    n = 0;
    moved = 1'b0;
    while (!cal_finish && n < 40) begin
      if (n == 10) acc_clr = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!cal_finish && result !== prev) moved = 1'b1;
    end
    if (!cal_finish) begin
      checks++; errors++;
      $display("FAIL finish_timeout: no cal_finish within %0d cycles", n);
    end else begin
      chk("latency", n, WIDTH);
      chk("result_hold_calc", moved, 0);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_finish: scoreboard empty");
      end else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("overflow", overflow, e.ov);
      end
      @(posedge clk); #1;
      chk("finish_one_cycle", cal_finish, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  // Issue one op; operands/acc_clr are scrambled after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic clr, input logic [ACC_W-1:0] er, input logic eov);
    logic [ACC_W-1:0] prev;
    exp_t e;
    @(negedge clk);
    op_a = a; op_b = b; acc_clr = clr; cal_start = 1'b1;
    e.r = er; e.ov = eov;
    sb.push_back(e);
    @(posedge clk); #1;
    cal_start = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    acc_clr = 1'b1;
    prev = result;
    chk("busy_calc", busy, 1);
    wait_finish(prev);
  endtask

  vec_t tbl[6];

  initial begin
    logic [63:0] full, mask;
    int          nfin, last_k, bad;
    exp_t        e;

    tbl[0] = '{16'd3,      16'd5,      1'b1, 36'd15,           1'b0};
    tbl[1] = '{16'hFFFF,   16'hFFFF,   1'b0, 36'h0FFFE0010,    1'b0};
    tbl[2] = '{16'h0000,   16'hFFFF,   1'b0, 36'h0FFFE0010,    1'b0};
    tbl[3] = '{16'h1234,   16'h0010,   1'b1, 36'h000012340,    1'b0};
    tbl[4] = '{16'h8000,   16'h0002,   1'b0, 36'h000022340,    1'b0};
    tbl[5] = '{16'hFFFF,   16'h0001,   1'b1, 36'h00000FFFF,    1'b0};

    rst = 1'b0; cal_start = 1'b0; acc_clr = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_finish", cal_finish, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].r, tbl[i].ov);

    // 17 max-value ops from a cleared accumulator; carry-out on the 17th.
    mask = (64'd1 << ACC_W) - 64'd1;
    for (int k = 1; k <= 17; k++) begin
      full = 64'(k) * 64'hFFFE0001;
      run_op(16'hFFFF, 16'hFFFF, (k == 1), ACC_W'(full & mask), (full >> ACC_W) != 0);
    end
    chk("ovf_result17", result, 36'h0FFDE0011);
    chk("ovf_sticky", overflow, 1);

    // IDLE clear drops both result and sticky overflow, no finish.
    @(negedge clk); acc_clr = 1'b1;
    @(posedge clk); #1;
    chk("idle_clr_result", result, 0);
    chk("idle_clr_ovf", overflow, 0);
    chk("idle_clr_finish", cal_finish, 0);
    chk("idle_clr_busy", busy, 0);
    acc_clr = 1'b0;

    run_op(16'd3, 16'd5, 1'b0, 36'd15, 1'b0);
    @(negedge clk); acc_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr15_result", result, 0);
    chk("clr15_finish", cal_finish, 0);
    acc_clr = 1'b0;

    // cal_start held 40 cycles: accepts at edges 0, 18, 36 -> results 1,2,3.
    for (int j = 1; j <= 3; j++) begin
      e.r = ACC_W'(j); e.ov = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk); op_a = 16'd1; op_b = 16'd1; acc_clr = 1'b0; cal_start = 1'b1;
    nfin = 0; last_k = -1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (k == 39) cal_start = 1'b0;
      if (cal_finish) begin
        if (last_k >= 0) chk("b2b_period", k - last_k, WIDTH+2);
        else             chk("b2b_first", k, WIDTH);
        last_k = k;
        nfin++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_extra: unexpected cal_finish at cycle %0d", k);
        end else begin
          e = sb.pop_front();
          chk("b2b_result", result, e.r);
        end
      end
    end
    chk("b2b_count", nfin, 3);
    chk("b2b_idle", busy, 0);

    // Reset 5 cycles into CALC aborts without writing result.
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 36'h0FFFE0004, 1'b0);
    @(negedge clk); op_a = 16'd5; op_b = 16'd5; acc_clr = 1'b0; cal_start = 1'b1;
    @(posedge clk); #1; cal_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_finish", cal_finish, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (cal_finish || busy) bad++;
    end
    chk("abort_no_finish", bad, 0);

    run_op(16'd2, 16'd3, 1'b0, 36'd6, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
